// File: rtl/console_pkg.sv
// console_pkg
// Constants, character codes, writer state encoding and the printable-byte
// test shared by the console writer and the console pixel driver.
// No ports; import with "import console_pkg::*;".
package console_pkg;

  // Screen geometry: 80x30 cells of 8x16 glyphs at 640x480.
  localparam int CONSOLE_COLS = 80;
  localparam int CONSOLE_ROWS = 30;

  // Character codes interpreted by the writer.
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_DEL   = 8'h7F;

  // Writer states: full-screen clear, accepting bytes, single-row clear.
  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } writerStateT;

  // Bytes stored as glyphs: 0x20..0x7E plus the whole upper half 0x80..0xFF.
  function automatic logic is_printable(input logic [7:0] c);
    return ((c >= CH_SPACE) && (c < CH_DEL)) || c[7];
  endfunction

endpackage

// File: rtl/console_writer.sv
// console_writer
// Write-side front end of the console character RAM. Consumes a byte stream
// over valid/ready and behaves as a minimal terminal: printable bytes are
// written at the cursor, CR/LF/BS move the cursor, FF clears the screen.
// The whole buffer is cleared to spaces after reset, and a row is cleared
// when the cursor wraps from the last row back to the top.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active low
//   inChar     incoming byte
//   inValid    inChar valid
//   inReady    byte accepted on an edge with inValid & inReady
//   addrWChar  RAM write address, row*COLS+col
//   dataWChar  RAM write data
//   weChar     RAM write enable, one cell per cycle
//   cursorCol  cursor column
//   cursorRow  cursor row
//   busy       high while a clear sweep is running
module console_writer
  import console_pkg::*;
#(
  parameter int COLS   = CONSOLE_COLS,
  parameter int ROWS   = CONSOLE_ROWS,
  parameter int ADDR_W = 13,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        inChar,
  input  logic              inValid,
  output logic              inReady,
  output logic [ADDR_W-1:0] addrWChar,
  output logic [7:0]        dataWChar,
  output logic              weChar,
  output logic [COL_W-1:0]  cursorCol,
  output logic [ROW_W-1:0]  cursorRow,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_SWEEP_COL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

  writerStateT       state, stateNext;
  logic [ADDR_W-1:0] sweepCnt, sweepNext;
  logic [ADDR_W-1:0] rowBase, rowBaseNext;
  logic [COL_W-1:0]  colNext;
  logic [ROW_W-1:0]  rowNext;
  logic              weNext;
  logic [ADDR_W-1:0] addrNext;
  logic [7:0]        dataNext;
  logic              doNewline;

  // Next-state and next-output logic. Every output is registered, so the
  // handshake flags are derived from the state being entered; that way
  // inReady rises in the same cycle the final sweep write is presented and
  // the block is unavailable for exactly the length of the sweep.
  // rowBase tracks row*COLS so addresses need only an adder.
  always_comb begin
    stateNext   = state;
    sweepNext   = sweepCnt;
    rowBaseNext = rowBase;
    colNext     = cursorCol;
    rowNext     = cursorRow;
    weNext      = 1'b0;
    addrNext    = addrWChar;
    dataNext    = dataWChar;
    doNewline   = 1'b0;

    case (state)
      CLEAR_ALL: begin
        weNext    = 1'b1;
        addrNext  = sweepCnt;
        dataNext  = CH_SPACE;
        sweepNext = sweepCnt + ADDR_W'(1);
        if (sweepCnt == LAST_CELL) begin
          stateNext   = IDLE;
          sweepNext   = '0;
          colNext     = '0;
          rowNext     = '0;
          rowBaseNext = '0;
        end
      end

      CLEAR_ROW: begin
        weNext    = 1'b1;
        addrNext  = rowBase + sweepCnt;
        dataNext  = CH_SPACE;
        sweepNext = sweepCnt + ADDR_W'(1);
        if (sweepCnt == LAST_SWEEP_COL) begin
          stateNext = IDLE;
          sweepNext = '0;
        end
      end

      IDLE: begin
        if (inValid && inReady) begin
          if (is_printable(inChar)) begin
            weNext   = 1'b1;
            addrNext = rowBase + ADDR_W'(cursorCol);
            dataNext = inChar;
            if (cursorCol < LAST_COL) begin
              colNext = cursorCol + COL_W'(1);
            end else begin
              doNewline = 1'b1;
            end
          end else begin
            case (inChar)
              CH_CR: colNext = '0;
              CH_LF: doNewline = 1'b1;
              CH_BS: begin
                // Backspace at column 0 is swallowed: no write, no row move.
                if (cursorCol != '0) begin
                  colNext  = cursorCol - COL_W'(1);
                  weNext   = 1'b1;
                  addrNext = rowBase + ADDR_W'(cursorCol - COL_W'(1));
                  dataNext = CH_SPACE;
                end
              end
              CH_FF: begin
                stateNext = CLEAR_ALL;
                sweepNext = '0;
              end
              default: ;
            endcase
          end

          // Wrapping past the last row scrolls nothing; the top row is
          // blanked instead so the new line starts on a clean row.
          if (doNewline) begin
            colNext = '0;
            if (cursorRow < LAST_ROW) begin
              rowNext     = cursorRow + ROW_W'(1);
              rowBaseNext = rowBase + ROW_STEP;
            end else begin
              rowNext     = '0;
              rowBaseNext = '0;
              stateNext   = CLEAR_ROW;
              sweepNext   = '0;
            end
          end
        end
      end

      default: begin
        stateNext = CLEAR_ALL;
        sweepNext = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; a reset
  // mid-sweep restarts the full clear from address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR_ALL;
      sweepCnt  <= '0;
      rowBase   <= '0;
      cursorCol <= '0;
      cursorRow <= '0;
      weChar    <= 1'b0;
      addrWChar <= '0;
      dataWChar <= '0;
      inReady   <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= stateNext;
      sweepCnt  <= sweepNext;
      rowBase   <= rowBaseNext;
      cursorCol <= colNext;
      cursorRow <= rowNext;
      weChar    <= weNext;
      addrWChar <= addrNext;
      dataWChar <= dataNext;
      inReady   <= (stateNext == IDLE);
      busy      <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer
// Directed bench for console_writer. A small cursor model turns every byte
// sent into the RAM writes it should cause and queues them; a monitor pops
// and compares on each presented write.
module tb_console_writer;
  import console_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  inChar = 8'h00;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [12:0] addrWChar;
  logic [7:0]  dataWChar;
  logic        weChar;
  logic [6:0]  cursorCol;
  logic [4:0]  cursorRow;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [20:0] expQ[$];
  int mCol = 0;
  int mRow = 0;

  int cycleNo = 0;
  int writeCount = 0;
  int lastWrCycle = 0;
  int prevWrCycle = 0;
  int runLen = 0;
  int lastRun = 0;

  console_writer dut (
    .clk(clk),
    .rst_n(rst_n),
    .inChar(inChar),
    .inValid(inValid),
    .inReady(inReady),
    .addrWChar(addrWChar),
    .dataWChar(dataWChar),
    .weChar(weChar),
    .cursorCol(cursorCol),
    .cursorRow(cursorRow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every presented write must match the oldest queued
  // expectation; also tracks write timing and lengths of write bursts.
  always @(negedge clk) begin
    logic [20:0] exp;
    cycleNo++;
    if (weChar === 1'b1) begin
      writeCount++;
      prevWrCycle = lastWrCycle;
      lastWrCycle = cycleNo;
      runLen++;
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $error("[TB] FAIL unexpectedWrite observed addr=%0d data=%0h expected no write",
               addrWChar, dataWChar);
      end else begin
        exp = expQ.pop_front();
        assert ({addrWChar, dataWChar} === exp) else begin
          miscompares++;
          $error("[TB] FAIL ramWrite observed addr=%0d data=%0h expected addr=%0d data=%0h",
                 addrWChar, dataWChar, exp[20:8], exp[7:0]);
        end
      end
    end else begin
      if (runLen > 0) lastRun = runLen;
      runLen = 0;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pushWrite(input int addr, input int data);
    expQ.push_back({13'(addr), 8'(data)});
  endtask

  task automatic pushClearAll();
    for (int a = 0; a < CELLS; a++) pushWrite(a, 8'h20);
  endtask

  task automatic modelNewline();
    mCol = 0;
    if (mRow < ROWS - 1) begin
      mRow++;
    end else begin
      mRow = 0;
      for (int c = 0; c < COLS; c++) pushWrite(c, 8'h20);
    end
  endtask

  // Terminal model: what a byte should do to the cursor and RAM.
  task automatic modelByte(input logic [7:0] b);
    if ((b >= 8'h20 && b <= 8'h7E) || b >= 8'h80) begin
      pushWrite(mRow * COLS + mCol, b);
      if (mCol < COLS - 1) mCol++;
      else modelNewline();
    end else if (b == 8'h0D) begin
      mCol = 0;
    end else if (b == 8'h0A) begin
      modelNewline();
    end else if (b == 8'h08) begin
      if (mCol > 0) begin
        mCol--;
        pushWrite(mRow * COLS + mCol, 8'h20);
      end
    end else if (b == 8'h0C) begin
      pushClearAll();
      mCol = 0;
      mRow = 0;
    end
  endtask

  // Waits (bounded) for inReady, presents the byte for one accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    while (inReady !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (inReady !== 1'b1) begin
      checkOutput("readyTimeout", 0, 1);
    end else begin
      modelByte(b);
      inChar  = b;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitReady(input int limit);
    int n = 0;
    while (inReady !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (inReady !== 1'b1) checkOutput("readyTimeout", 0, 1);
  endtask

  task automatic checkCursor(input string tag);
    checkOutput({tag, "Col"}, int'(cursorCol), mCol);
    checkOutput({tag, "Row"}, int'(cursorRow), mRow);
  endtask

  task automatic checkResetState();
    checkOutput("rstWe", int'(weChar), 0);
    checkOutput("rstReady", int'(inReady), 0);
    checkOutput("rstBusy", int'(busy), 1);
    checkOutput("rstAddr", int'(addrWChar), 0);
    checkOutput("rstData", int'(dataWChar), 0);
    checkOutput("rstCol", int'(cursorCol), 0);
    checkOutput("rstRow", int'(cursorRow), 0);
  endtask

  initial begin
    int wc;
    int lowCycles;
    int n;

    // Reset values while rst_n is held low.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    checkResetState();

    // Release: full clear of 2400 cells, then ready with cursor at home.
    pushClearAll();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("sweepBusy", int'(busy), 1);
    waitReady(3000);
    settle();
    checkOutput("clearRunLen", lastRun, CELLS);
    checkOutput("clearQueueEmpty", expQ.size(), 0);
    checkOutput("idleBusy", int'(busy), 0);
    checkOutput("idleReady", int'(inReady), 1);
    checkCursor("afterClear");

    // Back-to-back printable bytes land on consecutive cycles.
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    settle();
    checkOutput("abConsecutive", lastWrCycle - prevWrCycle, 1);
    checkCursor("afterAB");
    checkOutput("abCol", int'(cursorCol), 2);

    // Fill a row exactly, then one more byte wraps onto the next row.
    applyStimulus(8'h0D);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h78);
    settle();
    checkCursor("rowFull");
    checkOutput("rowFullRow", int'(cursorRow), 1);
    applyStimulus(8'h79);
    settle();
    checkCursor("afterWrap");

    // Backspace twice erases, third at column 0 is a no-op.
    applyStimulus(8'h0D);
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h08);
    applyStimulus(8'h08);
    settle();
    checkCursor("afterBs");
    wc = writeCount;
    applyStimulus(8'h08);
    settle();
    settle();
    checkOutput("bsAtCol0NoWrite", writeCount - wc, 0);
    checkCursor("bsAtCol0");

    // Ignored control bytes and DEL, then a high-half printable byte.
    wc = writeCount;
    applyStimulus(8'h00);
    applyStimulus(8'h7F);
    applyStimulus(8'h1B);
    settle();
    settle();
    checkOutput("ignoredNoWrite", writeCount - wc, 0);
    checkCursor("ignored");
    applyStimulus(8'h80);
    settle();
    checkCursor("highByte");

    // Walk to the last row, then LF wraps and clears row 0 for 80 cycles.
    applyStimulus(8'h0D);
    while (mRow < ROWS - 1) applyStimulus(8'h0A);
    settle();
    checkCursor("lastRow");
    checkOutput("lastRowIdx", int'(cursorRow), ROWS - 1);
    applyStimulus(8'h0A);
    lowCycles = 0;
    n = 0;
    @(negedge clk);
    while (inReady !== 1'b1 && n < 500) begin
      lowCycles++;
      n++;
      @(negedge clk);
    end
    checkOutput("rowClearLowCycles", lowCycles, COLS);
    settle();
    checkCursor("afterRowClear");
    checkOutput("rowClearQueueEmpty", expQ.size(), 0);

    // Form feed mid-screen, then reset during the sweep at address 1000.
    applyStimulus(8'h5A);
    applyStimulus(8'h0C);
    n = 0;
    @(negedge clk);
    while (!(weChar === 1'b1 && addrWChar == 13'd1000) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ffReachedAddr1000", int'(addrWChar), 1000);
    checkOutput("ffSweepBusy", int'(busy), 1);
    checkOutput("ffSweepReady", int'(inReady), 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    settle();
    checkResetState();
    expQ.delete();
    mCol = 0;
    mRow = 0;
    pushClearAll();
    rst_n = 1'b1;
    @(negedge clk);
    waitReady(3000);
    settle();
    checkOutput("restartRunLen", lastRun, CELLS);
    checkOutput("restartQueueEmpty", expQ.size(), 0);
    checkCursor("afterRestart");

    // One write after the restart proves the block accepts bytes again.
    applyStimulus(8'h51);
    settle();
    checkCursor("final");
    checkOutput("finalQueueEmpty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
